// File: rtl/cont_nbits_updown_if.sv
// Control/status bundle for cont_nbits_updown.
// master drives enable/up_down/load/data_in; slave returns count/tc/wrap/sat.
interface cont_nbits_updown_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             sat;

  modport master (
    output enable,
    output up_down,
    output load,
    output data_in,
    input  count,
    input  tc,
    input  wrap,
    input  sat
  );

  modport slave (
    input  enable,
    input  up_down,
    input  load,
    input  data_in,
    output count,
    output tc,
    output wrap,
    output sat
  );
endinterface

// File: rtl/cont_nbits_updown.sv
// Modulo-N up/down counter with clamped load, wrap pulse and sticky saturation.
// Ports: clk, reset (async active-low), bus (slave: enable/up_down/load/data_in in; count/tc/wrap/sat out).
module cont_nbits_updown #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULO   = 10,
  parameter bit              SATURATE = 1'b0
) (
  input logic               clk,
  input logic               reset,
  cont_nbits_updown_if.slave bus
);

  // Elaboration-time parameter sanity.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("cont_nbits_updown: WIDTH out of range 2..32");
  end
  if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("cont_nbits_updown: MODULO out of range 2..2**WIDTH");
  end

  // Top of range computed in 64 bits so MODULO = 2**WIDTH never overflows.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 64'd1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_oor;
  logic             w_tc;
  logic             w_step;
  logic             w_fix;
  logic             w_bnd;
  logic             w_inc;
  logic             w_dec;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_sat;

  assign w_at_max  = (r_count == MAX);
  assign w_at_zero = (r_count == '0);
  assign w_oor     = (r_count > MAX);

  assign w_tc = bus.enable
              & ((bus.up_down & w_at_max)
              | (~bus.up_down & w_at_zero));

  assign w_load_val = (bus.data_in > MAX)
                    ? MAX : bus.data_in;

  // One-hot step selects; load outranks any enabled step.
  assign w_step = ~bus.load & bus.enable;
  assign w_fix  = w_step & w_oor;
  assign w_bnd  = w_step & ~w_oor & w_tc;
  assign w_inc  = w_step & ~w_oor & ~w_tc
                & bus.up_down;
  assign w_dec  = w_step & ~w_oor & ~w_tc
                & ~bus.up_down;

  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    w_sat  = r_sat;
    unique case (1'b1)
      bus.load: begin
        w_next = w_load_val;
        w_sat  = 1'b0;
      end
      w_fix: begin
        w_next = '0;
      end
      w_bnd: begin
        if (SATURATE) begin
          w_sat = 1'b1;
        end else begin
          w_next = bus.up_down ? '0 : MAX;
          w_wrap = 1'b1;
        end
      end
      w_inc: begin
        w_next = r_count + 1'b1;
      end
      w_dec: begin
        w_next = r_count - 1'b1;
      end
      default: begin
        w_next = r_count;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_wrap;
      r_sat   <= w_sat;
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = w_tc;
  assign bus.wrap  = r_wrap;
  assign bus.sat   = r_sat;

endmodule
